apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB3 initiator that converts a simple request/grant command port into single APB transfers with SETUP and ACCESS phases. It sits upstream of the APB node: its APB outputs drive the node's slave-side inputs, and the node decodes the address to one of its downstream ports. One transfer is outstanding at a time. A programmable timeout aborts transfers whose responder never asserts `pready`.

## Interface
Parameters:
- `APB_ADDR_WIDTH`, default 32: `paddr_o` and `addr_i` width.
- `APB_DATA_WIDTH`, default 32: `pwdata_o`, `prdata_i`, `wdata_i` and `rdata_o` width.
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles before an abort. 0 disables the timeout.

Ports:
- `clk_i`  in  1  single clock. All logic is rising-edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `req_i`  in  1  command request.
- `gnt_o`  out  1  command accepted when `req_i && gnt_o`.
- `addr_i`  in  APB_ADDR_WIDTH  command address.
- `we_i`  in  1  1 = write, 0 = read.
- `wdata_i`  in  APB_DATA_WIDTH  write data.
- `rvalid_o`  out  1  response valid.
- `rready_i`  in  1  response accepted when `rvalid_o && rready_i`.
- `rdata_o`  out  APB_DATA_WIDTH  read data. Always 0 for writes and for aborted transfers.
- `err_o`  out  1  `pslverr_i` captured at completion, or 1 on timeout.
- `psel_o`, `penable_o`, `pwrite_o`  out  1 each  APB control.
- `paddr_o`  out  APB_ADDR_WIDTH  APB address.
- `pwdata_o`  out  APB_DATA_WIDTH  APB write data.
- `prdata_i`  in  APB_DATA_WIDTH  APB read data.
- `pready_i`, `pslverr_i`  in  1 each  APB completion and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Encoded state is registered.
- IDLE
  - `gnt_o` = 1, combinational from state. `gnt_o` is 0 in every other state.
  - On `req_i`: capture `addr_i`, `we_i`, `wdata_i` into `paddr_o`, `pwrite_o`, `pwdata_o`, then go to SETUP.
- SETUP: `psel_o` = 1, `penable_o` = 0. Go to ACCESS unconditionally.
- ACCESS
  - `psel_o` = 1, `penable_o` = 1. The timeout counter increments each ACCESS cycle.
  - `pready_i` = 1: capture `prdata_i` into `rdata_o` (reads only; writes load 0), capture `pslverr_i` into `err_o`, go to RESP.
  - `pready_i` = 0 in ACCESS cycle number TIMEOUT_CYCLES (TIMEOUT_CYCLES > 0): abort. Load `err_o` = 1 and `rdata_o` = 0, go to RESP.
  - If `pready_i` is high in that same cycle, normal completion wins.
- RESP
  - `rvalid_o` = 1; `psel_o` and `penable_o` are 0.
  - `rdata_o` and `err_o` are held stable until `rready_i`, then go to IDLE.
- `paddr_o`, `pwdata_o`, `pwrite_o` are held constant from the grant until the next grant. They keep their last values in IDLE and RESP.
- Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It is cleared on entering SETUP and does not wrap.
- Reset values: every output is 0 and the state is IDLE. Note `gnt_o` is the combinational decode of IDLE, so it reads 1 while `rst_ni` is low.
- Reset mid-transfer: `psel_o` and `penable_o` drop immediately (asynchronously). No response is issued, and any pending response is discarded.

## Timing
- Grant in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With zero wait states (`pready_i` high in cycle 2), `rvalid_o` rises in cycle 3.
- Each wait state adds one cycle. Latency from grant to `rvalid_o` = 3 + wait states.
- `rready_i` high in the cycle `rvalid_o` rises puts the block in IDLE in cycle 4, where it can grant again.
- Back-to-back throughput: one transfer per 4 cycles minimum.
- An aborted transfer asserts `rvalid_o` in cycle 2 + TIMEOUT_CYCLES.
- `rready_i` held low keeps RESP indefinitely. The APB bus stays idle and `gnt_o` stays 0.
- `req_i` in any state other than IDLE is ignored (no grant).

## Structure
- The shared package `apb_pkg` holds the state enum `apb_mst_state_e` (IDLE, SETUP, ACCESS, RESP) and the default width constants.
- No sub-module: the FSM, capture registers and counter fit in one module.

## Test plan
- Read, zero wait: request addr 0x1A10_0004; responder returns pready=1, prdata 0xDEAD_BEEF → `psel_o` seen in cycles 1-2, `penable_o` only in cycle 2, `rvalid_o` in cycle 3 with `rdata_o` = 0xDEAD_BEEF and `err_o` = 0.
- Write, 3 wait states: addr 0x1A10_1000, wdata 0x0000_00A5, we=1 → `paddr_o`, `pwdata_o` and `pwrite_o` stable through SETUP and 4 ACCESS cycles; `rvalid_o` in cycle 6 with `rdata_o` = 0.
- Slave error: read with pslverr=1 and pready=1 → `err_o` = 1 together with `rvalid_o`.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 → abort after 4 ACCESS cycles, `rvalid_o` in cycle 6 with `err_o` = 1 and `rdata_o` = 0. Repeat with pready rising in ACCESS cycle 4 → normal completion, `err_o` = 0.
- Backpressure: `rready_i` = 0 for 5 cycles with `req_i` held high → `gnt_o` = 0 and `psel_o` = 0 throughout; after acceptance, the second grant occurs in the next cycle.
- Reset in ACCESS: assert `rst_ni` low mid-wait → `psel_o` and `penable_o` go to 0 without waiting for a clock edge; after release, `rvalid_o` stays 0 and `gnt_o` = 1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: initiator FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH_DEF = 32;
    localparam int unsigned APB_DATA_WIDTH_DEF = 32;
    localparam int unsigned APB_TIMEOUT_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns one granted request/response command into a single
// SETUP+ACCESS transfer, with an optional ACCESS-phase timeout.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int unsigned APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned CNT_W   = ($clog2(TIMEOUT_CYCLES + 1) > 1) ?
                                      $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

    apb_mst_state_e   state;
    logic [CNT_W-1:0] to_cnt;

    // Grant is a pure decode of IDLE, so it is high during reset as well.
    assign gnt_o = (state == ST_IDLE);

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        paddr_o  <= addr_i;
                        pwrite_o <= we_i;
                        pwdata_o <= wdata_i;
                        psel_o   <= 1'b1;
                        to_cnt   <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (to_cnt != {CNT_W{1'b1}}) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                    // A ready in the final timeout cycle still completes normally.
                    if (pready_i) begin
                        rdata_o   <= pwrite_o ? '0 : prdata_i;
                        err_o     <= pslverr_i;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        state     <= ST_RESP;
                    end else if (TO_EN && (to_cnt == CNT_W'(TO_LAST))) begin
                        rdata_o   <= '0;
                        err_o     <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rready_i) begin
                        rvalid_o <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of single transfers plus
// backpressure and mid-transfer reset sequences.
module tb_apb_cmd_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk, rst_n;
    logic          req, gnt, we, rvalid, rready, err;
    logic [AW-1:0] addr, paddr;
    logic [DW-1:0] wdata, rdata, pwdata, prdata;
    logic          psel, penable, pwrite, pready, pslverr;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .err_o(err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
        .pready_i(pready), .pslverr_i(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            waits;      // -1: responder never ready
        int            exp_lat;    // grant cycle to rvalid cycle
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one transfer; entered and left just after a rising edge in IDLE.
    task automatic run_xfer(input int idx, input vec_t v);
        int got;
        string tag;
        tag = $sformatf("v%0d", idx);
        req = 1'b1; addr = v.addr; we = v.we; wdata = v.wdata;
        @(negedge clk);
        check({tag, "_gnt"}, 64'(gnt), 64'd1);
        @(posedge clk); #1;
        req = 1'b0; addr = '0; wdata = '0; we = 1'b0;
        got = -1;
        for (int c = 1; c <= 20; c++) begin
            pready  = (v.waits >= 0) && (c == 2 + v.waits);
            prdata  = v.prdata;
            pslverr = v.slverr;
            @(negedge clk);
            if (rvalid) begin
                got = c;
                break;
            end
            check({tag, "_psel"}, 64'(psel), 64'd1);
            check({tag, "_penable"}, 64'(penable), 64'(c >= 2));
            check({tag, "_paddr"}, 64'(paddr), 64'(v.addr));
            check({tag, "_pwdata"}, 64'(pwdata), 64'(v.wdata));
            check({tag, "_pwrite"}, 64'(pwrite), 64'(v.we));
            check({tag, "_gnt_busy"}, 64'(gnt), 64'd0);
            @(posedge clk); #1;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        check({tag, "_latency"}, 64'(got), 64'(v.exp_lat));
        check({tag, "_rdata"}, 64'(rdata), 64'(v.exp_rdata));
        check({tag, "_err"}, 64'(err), 64'(v.exp_err));
        check({tag, "_psel_resp"}, 64'({psel, penable}), 64'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
        check({tag, "_gnt_idle"}, 64'(gnt), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h1A10_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h1A10_1000, 32'h0000_00A5, 32'h1234_5678, 1'b0, 3, 6, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h1A10_2008, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 4, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b0, 32'h1A10_3000, 32'h0, 32'h55AA_55AA, 1'b0, -1, 6, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 32'h1A10_300C, 32'h0, 32'h0BAD_C0DE, 1'b0, 3, 6, 32'h0BAD_C0DE, 1'b0};
        vecs[5] = '{1'b1, 32'h1A10_4010, 32'hFFFF_0001, 32'h7777_7777, 1'b1, 2, 5, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 32'h1A10_5014, 32'h0F0F_0F0F, 32'h9999_9999, 1'b0, -1, 6, 32'h0, 1'b1};

        req = 0; addr = '0; we = 0; wdata = '0; rready = 0;
        prdata = '0; pready = 0; pslverr = 0;
        rst_n = 1'b0;
        #12;
        check("rst_gnt", 64'(gnt), 64'd1);
        check("rst_outs", 64'({rvalid, err, psel, penable, pwrite}), 64'd0);
        check("rst_buses", 64'({rdata, paddr}), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

        // Backpressure: response held with req_i high, then immediate regrant.
        req = 1'b1; addr = 32'h1A10_6000; we = 1'b0;
        @(negedge clk);
        check("bp_gnt0", 64'(gnt), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pready = 1'b1; prdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        pready = 1'b0; prdata = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rvalid", 64'(rvalid), 64'd1);
            check("bp_gnt", 64'(gnt), 64'd0);
            check("bp_psel", 64'(psel), 64'd0);
            check("bp_rdata", 64'(rdata), 64'h1357_9BDF);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("bp_regrant", 64'(gnt), 64'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("bp_setup2", 64'({psel, penable}), 64'd2);
        @(posedge clk); #1;
        pready = 1'b1; prdata = 32'h2468_ACE0;
        @(posedge clk); #1;
        pready = 1'b0;
        @(negedge clk);
        check("bp_rvalid2", 64'(rvalid), 64'd1);
        check("bp_rdata2", 64'(rdata), 64'h2468_ACE0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;

        // Reset while waiting in ACCESS.
        req = 1'b1; addr = 32'h1A10_7000; we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rs_access", 64'({psel, penable}), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rs_psel_async", 64'({psel, penable}), 64'd0);
        check("rs_gnt", 64'(gnt), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rs_rvalid", 64'(rvalid), 64'd0);
            check("rs_gnt_after", 64'(gnt), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
